// File: rtl/sub_pipe_pkg.sv
// Shared definitions for the sub_pipe signed subtractor: default widths,
// the signed data type, saturation limits and the overflow-detect helper.
package sub_pipe_pkg;

  localparam int DW_DEF = 16;
  localparam int CW_DEF = 16;

  typedef logic signed [DW_DEF-1:0] data_t;

  localparam data_t SMAX = 16'sh7FFF;
  localparam data_t SMIN = 16'sh8000;

  // Overflow when the two MSBs of the sign-extended (DW+1)-bit difference disagree
  function automatic logic ovf_detect(input logic [1:0] top2);
    return top2[1] ^ top2[0];
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Generic valid/ready register slice of width W; holds its contents while
// the downstream stalls and loads whenever it is empty or being drained.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);

  assign in_ready = !out_valid || out_ready;

  // Data only updates on a real transfer so a bubble never disturbs dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) dout <= din;
    end
  end

endmodule

// File: rtl/sub_pipe.sv
// Two-stage back-pressured signed subtractor dout = dina - dinb with overflow
// flag and saturating overflow counter. Define SUB_PIPE_SAT_EN to clamp on overflow.
module sub_pipe
  import sub_pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dina,
  input  logic [DW-1:0] dinb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic          ovf,
  output logic [CW-1:0] ovf_cnt,
  input  logic          cnt_clr
);

  logic            s1_v;
  logic            s1_ready;
  logic            s2_load;
  logic [2*DW-1:0] s1_q;
  logic [DW:0]     s2_q;
  logic [DW-1:0]   opa;
  logic [DW-1:0]   opb;
  logic [DW:0]     diff;
  logic            ovf_w;
  logic [DW-1:0]   res;

  pipe_stage #(.W(2*DW)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s1_ready),
    .din       ({dina, dinb}),
    .out_valid (s1_v),
    .out_ready (s2_load),
    .dout      (s1_q)
  );

  assign opa   = s1_q[2*DW-1:DW];
  assign opb   = s1_q[DW-1:0];
  assign diff  = {opa[DW-1], opa} - {opb[DW-1], opb};
  assign ovf_w = ovf_detect(diff[DW:DW-1]);

`ifdef SUB_PIPE_SAT_EN
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  always_comb begin
    res = diff[DW-1:0];
    if (ovf_w) res = opa[DW-1] ? SAT_MIN : SAT_MAX;
  end
`else
  assign res = diff[DW-1:0];
`endif

  pipe_stage #(.W(DW+1)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_v),
    .in_ready  (s2_load),
    .din       ({ovf_w, res}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (s2_q)
  );

  assign ovf      = s2_q[DW];
  assign dout     = s2_q[DW-1:0];
  assign in_ready = s1_ready && !rst;

  // Counts delivered overflowed results; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && ovf && (ovf_cnt != {CW{1'b1}})) begin
      ovf_cnt <= ovf_cnt + CW'(1);
    end
  end

endmodule
